ram_sma_truth_table_writer: RTL and testbench

- Writer side of the shift-and-add truth-table memory: generates the full a+b sum table, writes it into an internal synchronous RAM, reads it back to verify it, then serves registered lookups.
- It is the fill/load counterpart of the ROM-based adder. It lets the table be rebuilt at run time instead of being fixed at synthesis.
- Sits between the control logic that requests a (re)build and the datapath that consumes sums.

---
 rtl/ram_sma_truth_table_writer.sv | 124 ++++++++++++
 tb/tb_ram_sma_truth_table_writer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ram_sma_truth_table_writer.sv
// rtl/ram_sma_truth_table_writer.sv - builds, verifies and serves an a+b truth table held in a synchronous RAM
module ram_sma_truth_table_writer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flt_inj,
  output logic                  busy,
  output logic                  ready,
  output logic                  error,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH:0]   sum,
  output logic                  sum_valid
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, READY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cmp_addr, addr;
  logic          rd_done, cmp_vld, we, re, start_ok;
  logic [SW-1:0] wdata, rdata, sum_hold;
  logic [SW-1:0] mem [2**AW];

  function automatic logic [SW-1:0] table_sum(input logic [AW-1:0] x);
    return SW'(x[AW-1:DATA_WIDTH]) + SW'(x[DATA_WIDTH-1:0]);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ready     = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    start_ok  = 1'b0;
    addr      = cnt;
    wdata     = table_sum(cnt);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
          start_ok  = 1'b1;
        end
      end
      FILL: begin
        busy = 1'b1;
        we   = 1'b1;
        if (flt_inj && cnt == '0) wdata = wdata ^ SW'(1);
        if (&cnt) state_nxt = VERIFY;
      end
      VERIFY: begin
        busy = 1'b1;
        re   = !rd_done;
        if (cmp_vld && &cmp_addr) state_nxt = READY;
      end
      READY: begin
        ready = 1'b1;
        addr  = {a, b};
        // A rebuild request takes priority over a coincident lookup.
        if (start) begin
          state_nxt = FILL;
          start_ok  = 1'b1;
        end else begin
          re = rd_en;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rd_done   <= 1'b0;
      cmp_vld   <= 1'b0;
      cmp_addr  <= '0;
      error     <= 1'b0;
      sum_valid <= 1'b0;
      sum_hold  <= '0;
    end else begin
      sum_valid <= (state == READY) && re;
      if (sum_valid) sum_hold <= rdata;
      cmp_vld <= 1'b0;
      if (start_ok) begin
        cnt     <= '0;
        error   <= 1'b0;
        rd_done <= 1'b0;
      end else if (state == FILL) begin
        cnt <= cnt + 1'b1;
      end else if (state == VERIFY) begin
        if (!rd_done) begin
          cnt     <= cnt + 1'b1;
          rd_done <= &cnt;
        end
        // Read data lands one cycle after issue, so the compare trails the read address.
        cmp_vld  <= !rd_done;
        cmp_addr <= cnt;
        if (cmp_vld && rdata != table_sum(cmp_addr)) error <= 1'b1;
      end
    end
  end

  assign sum = sum_valid ? rdata : sum_hold;

endmodule

// File: tb/tb_ram_sma_truth_table_writer.sv
// tb/tb_ram_sma_truth_table_writer.sv - scoreboard bench for ram_sma_truth_table_writer at DATA_WIDTH=4
module tb_ram_sma_truth_table_writer;

  logic       clk = 1'b0;
  logic       rst_n, start, flt_inj, rd_en;
  logic [3:0] a, b;
  logic       busy, ready, error, sum_valid;
  logic [4:0] sum;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] model[256];
  logic [4:0] last_sum = '0;

  ram_sma_truth_table_writer #(.DATA_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flt_inj(flt_inj),
    .busy(busy), .ready(ready), .error(error), .rd_en(rd_en),
    .a(a), .b(b), .sum(sum), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest expected lookup; otherwise sum must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_sum = '0;
    end else if (sum_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sum_valid", 1, 0);
      end else begin
        check("lookup_sum", int'(sum), int'(exp_q.pop_front()));
      end
      last_sum = sum;
    end else begin
      check("sum_hold", int'(sum), int'(last_sum));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model(input bit fi);
    for (int i = 0; i < 256; i++) model[i] = 5'((i / 16) + (i % 16));
    if (fi) model[0] = model[0] ^ 5'd1;
  endtask

  task automatic build(input bit fi, input bit junk, input bit with_rd);
    int n;
    n       = 0;
    flt_inj = fi;
    start   = 1'b1;
    rd_en   = with_rd;
    a       = 4'($urandom);
    b       = 4'($urandom);
    tick();
    start = 1'b0;
    rd_en = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("ready_after_start", int'(ready), 0);
    check("error_after_start", int'(error), 0);
    check("no_valid_after_start", int'(sum_valid), 0);
    for (int i = 1; i <= 600; i++) begin
      if (junk) begin
        rd_en = 1'($urandom);
        a     = 4'($urandom);
        b     = 4'($urandom);
        start = (i == 50 || i == 300);
      end
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    rd_en = 1'b0;
    check("ready_latency", n, 513);
    check("busy_when_ready", int'(busy), 0);
    check("error_when_ready", int'(error), int'(fi));
    set_model(fi);
  endtask

  task automatic lookup(input logic [3:0] av, input logic [3:0] bv, input logic en);
    a     = av;
    b     = bv;
    rd_en = en;
    if (ready && en && !start) exp_q.push_back(model[{av, bv}]);
    tick();
  endtask

  task automatic random_lookups(input int count);
    for (int i = 0; i < count; i++) lookup(4'($urandom), 4'($urandom), 1'($urandom));
    rd_en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    flt_inj = 1'b0;
    rd_en   = 1'b0;
    a       = '0;
    b       = '0;
    set_model(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(ready), 0);
    check("reset_error", int'(error), 0);
    check("reset_sum_valid", int'(sum_valid), 0);
    check("reset_sum", int'(sum), 0);
    rst_n = 1'b1;
    tick();

    build(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) lookup(4'(i), 4'(j), 1'b1);
    rd_en = 1'b0;
    tick();
    tick();
    random_lookups(200);

    build(1'b1, 1'b0, 1'b0);
    check("fault_ready", int'(ready), 1);
    lookup(4'd0, 4'd0, 1'b1);
    random_lookups(20);
    build(1'b0, 1'b0, 1'b0);
    lookup(4'd0, 4'd0, 1'b1);
    random_lookups(20);

    build(1'b0, 1'b1, 1'b0);
    random_lookups(40);

    flt_inj = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    check("midfill_reset_busy", int'(busy), 0);
    check("midfill_reset_ready", int'(ready), 0);
    check("midfill_reset_valid", int'(sum_valid), 0);
    check("midfill_reset_error", int'(error), 0);
    tick();
    rst_n = 1'b1;
    tick();
    build(1'b0, 1'b0, 1'b0);
    random_lookups(50);

    build(1'b0, 1'b0, 1'b1);
    random_lookups(50);

    rd_en = 1'b0;
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
